data_sram_responder: RTL and testbench

- Memory-side responder for the core's data SRAM port. It answers the en/wen/addr/wdata requests issued from EX and returns data_sram_rdata to the MEM stage.
- Holds a word-organised, byte-writable RAM and models a configurable access latency.
- For latency greater than 1 it raises a pipeline stall request, so the core sees the same one-cycle-later rdata timing for every latency.

---
 rtl/data_sram_responder_pkg.sv | 25 ++
 rtl/data_sram_responder_dsram_array.sv | 49 ++++
 rtl/data_sram_responder.sv | 162 ++++++++++++++++
 tb/tb_data_sram_responder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/data_sram_responder_pkg.sv
// Shared types and constants for the data SRAM responder: latency bus width,
// FSM state encodings, read-request encoding and the write-alignment helper.
package data_sram_responder_pkg;

  localparam int DSRAM_LAT_W = 3;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } dsram_state_e;

  localparam logic [3:0] DSRAM_WEN_READ = 4'b0000;

  // Full-word writes need addr[1:0]==0; half-word writes need addr[0]==0.
  function automatic logic dsram_misaligned(input logic [3:0] wen, input logic [1:0] lo);
    logic mis;
    case (wen)
      4'b1111:          mis = (lo != 2'b00);
      4'b0011, 4'b1100: mis = lo[0];
      default:          mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/data_sram_responder_dsram_array.sv
// Single-port 2**ADDR_W x 32 word RAM with byte write enables and a registered,
// resettable read-data output that holds between reads.
module dsram_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [3:0]        wr_be,
  input  logic [ADDR_W-1:0] idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];
  logic [31:0] rdata_d;
  logic [31:0] rdata_q;

  // Byte-lane writes; storage is never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_be[i]) begin
        mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read data only changes when a read completes.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = mem[idx];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Read data register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= 32'h0000_0000;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_sram_responder.sv
// Data SRAM responder: latency FSM, request capture and stall request around dsram_array.
// Optional write-alignment checking is enabled with `define DSRAM_ALIGN_CHK_EN.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq
`ifdef DSRAM_ALIGN_CHK_EN
  ,
  output logic        addr_err
`endif
);

  localparam logic [DSRAM_LAT_W-1:0] LAT_INIT = DSRAM_LAT_W'(LAT - 1);

  dsram_state_e            state_d, state_q;
  logic [DSRAM_LAT_W-1:0]  cnt_d, cnt_q;
  logic [ADDR_W+1:0]       cap_addr_d, cap_addr_q;
  logic [3:0]              cap_wen_d, cap_wen_q;
  logic [31:0]             cap_wdata_d, cap_wdata_q;

  logic                    done_s;
  logic                    stall_s;
  logic [ADDR_W+1:0]       req_addr_s;
  logic [3:0]              req_wen_s;
  logic [31:0]             req_wdata_s;
  logic                    rd_en_s;
  logic [3:0]              wr_be_s;

  // Accept/busy sequencing, capture of the request and the stall request.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cap_addr_d  = cap_addr_q;
    cap_wen_d   = cap_wen_q;
    cap_wdata_d = cap_wdata_q;
    done_s      = 1'b0;
    stall_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (data_sram_en) begin
          cap_addr_d  = data_sram_addr[ADDR_W+1:0];
          cap_wen_d   = data_sram_wen;
          cap_wdata_d = data_sram_wdata;
          if (LAT > 1) begin
            state_d = ST_BUSY;
            cnt_d   = LAT_INIT;
            stall_s = 1'b1;
          end else begin
            done_s  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_q == 3'd1) begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
          done_s  = 1'b1;
        end else begin
          cnt_d   = cnt_q - 3'd1;
          stall_s = (cnt_q > 3'd1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // Single-cycle latency completes straight from the core inputs.
  always_comb begin
    if (LAT == 1) begin
      req_addr_s  = data_sram_addr[ADDR_W+1:0];
      req_wen_s   = data_sram_wen;
      req_wdata_s = data_sram_wdata;
    end else begin
      req_addr_s  = cap_addr_q;
      req_wen_s   = cap_wen_q;
      req_wdata_s = cap_wdata_q;
    end
  end

`ifdef DSRAM_ALIGN_CHK_EN
  logic mis_s;
  logic addr_err_d, addr_err_q;

  // Misaligned writes are dropped but keep their normal timing.
  always_comb begin
    mis_s      = (req_wen_s != DSRAM_WEN_READ) && dsram_misaligned(req_wen_s, req_addr_s[1:0]);
    rd_en_s    = done_s && rst && (req_wen_s == DSRAM_WEN_READ);
    wr_be_s    = (done_s && rst && !mis_s) ? req_wen_s : 4'b0000;
    addr_err_d = done_s && rst && mis_s;
  end

  // One-cycle error pulse after a suppressed write completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= addr_err_d;
    end
  end

  assign addr_err = addr_err_q;

  logic unused_s;
  assign unused_s = ^data_sram_addr[31:ADDR_W+2];
`else
  // rst gates the array so nothing is written while reset is asserted.
  always_comb begin
    rd_en_s = done_s && rst && (req_wen_s == DSRAM_WEN_READ);
    wr_be_s = (done_s && rst) ? req_wen_s : 4'b0000;
  end

  logic unused_s;
  assign unused_s = ^{data_sram_addr[31:ADDR_W+2], req_addr_s[1:0]};
`endif

  // FSM, counter and capture registers; reset drops any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      cap_addr_q  <= '0;
      cap_wen_q   <= 4'b0000;
      cap_wdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cap_addr_q  <= cap_addr_d;
      cap_wen_q   <= cap_wen_d;
      cap_wdata_q <= cap_wdata_d;
    end
  end

  assign stallreq = stall_s && rst;

  dsram_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .rd_en (rd_en_s),
    .wr_be (wr_be_s),
    .idx   (req_addr_s[ADDR_W+1:2]),
    .wdata (req_wdata_s),
    .rdata (data_sram_rdata)
  );

endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench for data_sram_responder: three instances with LAT = 1, 2, 3
// (index k has LAT = k+1) driven one at a time from a byte-level memory model.
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_s    [3];
  logic [3:0]  wen_s   [3];
  logic [31:0] addr_s  [3];
  logic [31:0] wdata_s [3];
  logic [31:0] rdata_s [3];
  logic        stall_s [3];
`ifdef DSRAM_ALIGN_CHK_EN
  logic        err_s   [3];
`endif

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q [$];
  logic [31:0] mdl [3][1024];
  logic [31:0] last_rd [3];

  always #5 clk = ~clk;

  data_sram_responder #(.ADDR_W(10), .LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .data_sram_en(en_s[0]), .data_sram_wen(wen_s[0]),
    .data_sram_addr(addr_s[0]), .data_sram_wdata(wdata_s[0]),
    .data_sram_rdata(rdata_s[0]), .stallreq(stall_s[0])
`ifdef DSRAM_ALIGN_CHK_EN
    , .addr_err(err_s[0])
`endif
  );

  data_sram_responder #(.ADDR_W(10), .LAT(2)) u_lat2 (
    .clk(clk), .rst(rst), .data_sram_en(en_s[1]), .data_sram_wen(wen_s[1]),
    .data_sram_addr(addr_s[1]), .data_sram_wdata(wdata_s[1]),
    .data_sram_rdata(rdata_s[1]), .stallreq(stall_s[1])
`ifdef DSRAM_ALIGN_CHK_EN
    , .addr_err(err_s[1])
`endif
  );

  data_sram_responder #(.ADDR_W(10), .LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .data_sram_en(en_s[2]), .data_sram_wen(wen_s[2]),
    .data_sram_addr(addr_s[2]), .data_sram_wdata(wdata_s[2]),
    .data_sram_rdata(rdata_s[2]), .stallreq(stall_s[2])
`ifdef DSRAM_ALIGN_CHK_EN
    , .addr_err(err_s[2])
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic bit tb_misaligned(input logic [3:0] w, input logic [31:0] a);
`ifdef DSRAM_ALIGN_CHK_EN
    if (w == 4'hF) return (a[1:0] != 2'b00);
    if (w == 4'b0011 || w == 4'b1100) return a[0];
`endif
    return 1'b0;
  endfunction

  task automatic model_write(input int k, input logic [3:0] w, input logic [31:0] a,
                             input logic [31:0] d);
    logic [31:0] word;
    if (tb_misaligned(w, a)) return;
    word = mdl[k][a[11:2]];
    for (int i = 0; i < 4; i++) begin
      if (w[i]) word[8*i +: 8] = d[8*i +: 8];
    end
    mdl[k][a[11:2]] = word;
  endtask

  // Called at a falling edge; returns at the falling edge after completion.
  task automatic access(input int k, input logic [3:0] w, input logic [31:0] a,
                        input logic [31:0] d, input string tag, input bit scramble);
    int stalls;
    bit err_exp;
    err_exp = (w != 4'b0000) && tb_misaligned(w, a);
    en_s[k] = 1'b1; wen_s[k] = w; addr_s[k] = a; wdata_s[k] = d;
    if (w == 4'b0000) exp_q.push_back(mdl[k][a[11:2]]);
    else model_write(k, w, a, d);
    stalls = 0;
    #1;
    while (stall_s[k] === 1'b1 && stalls < 10) begin
      stalls++;
      @(posedge clk); #1;
      if (scramble) begin
        en_s[k] = 1'b1; wen_s[k] = 4'hF; addr_s[k] = 32'h24; wdata_s[k] = 32'h1234_5678;
      end
      @(negedge clk); #1;
    end
    check_eq({tag, "_stalls"}, 32'(stalls), 32'(k));
    @(posedge clk);
    @(negedge clk);
    en_s[k] = 1'b0; wen_s[k] = 4'b0000; addr_s[k] = 32'h0; wdata_s[k] = 32'h0;
    if (w == 4'b0000) begin
      if (exp_q.size() == 0) begin
        check_eq({tag, "_sb_empty"}, rdata_s[k], 32'hxxxx_xxxx);
      end else begin
        last_rd[k] = exp_q.pop_front();
        check_eq({tag, "_rdata"}, rdata_s[k], last_rd[k]);
      end
    end else begin
      check_eq({tag, "_hold"}, rdata_s[k], last_rd[k]);
    end
`ifdef DSRAM_ALIGN_CHK_EN
    check_eq({tag, "_err"}, 32'(err_s[k]), 32'(err_exp));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      en_s[k] = 1'b0; wen_s[k] = 4'b0000; addr_s[k] = 32'h0; wdata_s[k] = 32'h0;
      last_rd[k] = 32'h0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("rst_rdata%0d", k), rdata_s[k], 32'h0);
      check_eq($sformatf("rst_stall%0d", k), 32'(stall_s[k]), 32'h0);
    end
    rst = 1'b1;
    @(negedge clk);

    // LAT=1: full write/read, aliasing, byte-lane merge, idle hold, back-to-back
    access(0, 4'hF, 32'h10, 32'hDEAD_BEEF, "l1_wr10", 1'b0);
    access(0, 4'h0, 32'h10, 32'h0, "l1_rd10", 1'b0);
    access(0, 4'hF, 32'h0000_1010, 32'hCAFE_F00D, "l1_wr_alias", 1'b0);
    access(0, 4'h0, 32'h10, 32'h0, "l1_rd_alias", 1'b0);
    access(0, 4'hF, 32'h14, 32'h1122_3344, "l1_wr14", 1'b0);
    access(0, 4'b0010, 32'h14, 32'h0000_AB00, "l1_wr14_b1", 1'b0);
    access(0, 4'h0, 32'h14, 32'h0, "l1_rd14", 1'b0);
    repeat (3) @(negedge clk);
    check_eq("l1_idle_hold", rdata_s[0], last_rd[0]);
    access(0, 4'h0, 32'h10, 32'h0, "l1_b2b_a", 1'b0);
    access(0, 4'h0, 32'h14, 32'h0, "l1_b2b_b", 1'b0);

    // LAT=3: stall timing, inputs ignored while busy
    access(2, 4'hF, 32'h20, 32'h5A5A_5A5A, "l3_wr20", 1'b0);
    access(2, 4'hF, 32'h24, 32'h0BAD_F00D, "l3_wr24", 1'b0);
    access(2, 4'h0, 32'h20, 32'h0, "l3_rd20_scr", 1'b1);
    access(2, 4'h0, 32'h24, 32'h0, "l3_rd24", 1'b0);

    // LAT=3: reset during a busy write drops it
    access(2, 4'hF, 32'h30, 32'h0000_0000, "l3_wr30", 1'b0);
    access(2, 4'h0, 32'h20, 32'h0, "l3_rd20", 1'b0);
    en_s[2] = 1'b1; wen_s[2] = 4'hF; addr_s[2] = 32'h30; wdata_s[2] = 32'hFFFF_FFFF;
    #1;
    check_eq("l3_abort_stall_acc", 32'(stall_s[2]), 32'h1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check_eq("l3_abort_stall", 32'(stall_s[2]), 32'h0);
    check_eq("l3_abort_rdata", rdata_s[2], 32'h0);
    en_s[2] = 1'b0; wen_s[2] = 4'h0; addr_s[2] = 32'h0; wdata_s[2] = 32'h0;
    last_rd[2] = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    access(2, 4'h0, 32'h30, 32'h0, "l3_rd30", 1'b0);

    // LAT=2: back-to-back reads give stall pattern 1,0,1,0
    access(1, 4'hF, 32'h40, 32'hA1A2_A3A4, "l2_wr40", 1'b0);
    access(1, 4'hF, 32'h44, 32'hB1B2_B3B4, "l2_wr44", 1'b0);
    access(1, 4'h0, 32'h40, 32'h0, "l2_rd40", 1'b0);
    access(1, 4'h0, 32'h44, 32'h0, "l2_rd44", 1'b0);

`ifdef DSRAM_ALIGN_CHK_EN
    access(0, 4'hF, 32'h50, 32'h0102_0304, "al_wr50", 1'b0);
    access(0, 4'hF, 32'h52, 32'hFFFF_FFFF, "al_wr52_mis", 1'b0);
    @(negedge clk);
    check_eq("al_err_fall", 32'(err_s[0]), 32'h0);
    access(0, 4'h0, 32'h50, 32'h0, "al_rd50", 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
